// File: rtl/fmc_pkg.sv
// Shared definitions for the FMC initiator.
// Holds the FSM state encoding, the bus widths, the idle level of the
// strobes, the legal ranges of the timing parameters and a helper that turns
// a phase length into the phase-counter load value.
package fmc_pkg;

    localparam int FMC_ADDR_W  = 26;
    localparam int FMC_DATA_W  = 32;
    localparam int PHASE_CNT_W = 8;

    // {NE, NOE, NWE} when no bus cycle is in progress
    localparam logic [2:0] STROBE_IDLE = 3'b111;

    localparam int ADDSET_MIN  = 1;
    localparam int ADDSET_MAX  = 15;
    localparam int DATAST_MIN  = 1;
    localparam int DATAST_MAX  = 255;
    localparam int BUSTURN_MIN = 0;
    localparam int BUSTURN_MAX = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_DATA  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_TURN  = 3'd4
    } fmc_state_e;

    // A phase of N cycles loads N-1 so that it ends when the counter reads 0
    function automatic logic [PHASE_CNT_W-1:0] phase_load(input int len);
        phase_load = PHASE_CNT_W'(len - 1);
    endfunction

endpackage

// File: rtl/fmc_phase_counter.sv
// Loadable down-counter that times the FMC bus phases.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   load        - load load_val (has priority over en)
//   en          - decrement by one, saturating at zero
//   load_val    - value to load
//   zero        - counter currently reads zero
module fmc_phase_counter
    import fmc_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   en,
    input  logic [PHASE_CNT_W-1:0] load_val,
    output logic                   zero
);

    logic [PHASE_CNT_W-1:0] cnt_r;

    // Counter register: load, or count down while enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != '0)) begin
            cnt_r <= cnt_r - PHASE_CNT_W'(1);
        end
    end

    assign zero = (cnt_r == '0);

endmodule

// File: rtl/fmc_master.sv
// FMC initiator issuing asynchronous SRAM/NOR mode-1 read and write cycles
// from a command/response interface.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   io_cmd_*              - command: valid/ready handshake, write flag,
//                           address, write data
//   io_rsp_valid/rdata    - one-cycle pulse per completed read, read data
//                           (held until the next read completes)
//   io_fmc_master_A       - FMC address
//   io_fmc_master_D_*     - FMC data split into driven value, output enable
//                           and sampled value (joined into an inout at chip top)
//   io_fmc_master_NE/NOE/NWE - active-low strobes
// All FMC outputs are registered: each register is loaded with the value
// belonging to the state being entered, so outputs change on the same edge
// as the state.
module fmc_master
    import fmc_pkg::*;
#(
    parameter int ADDR_W  = FMC_ADDR_W,
    parameter int DATA_W  = FMC_DATA_W,
    parameter int ADDSET  = 2,
    parameter int DATAST  = 4,
    parameter int BUSTURN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_cmd_valid,
    output logic              io_cmd_ready,
    input  logic              io_cmd_write,
    input  logic [ADDR_W-1:0] io_cmd_addr,
    input  logic [DATA_W-1:0] io_cmd_wdata,
    output logic              io_rsp_valid,
    output logic [DATA_W-1:0] io_rsp_rdata,
    output logic [ADDR_W-1:0] io_fmc_master_A,
    output logic [DATA_W-1:0] io_fmc_master_D_out,
    output logic              io_fmc_master_D_oe,
    input  logic [DATA_W-1:0] io_fmc_master_D_in,
    output logic              io_fmc_master_NE,
    output logic              io_fmc_master_NOE,
    output logic              io_fmc_master_NWE
);

    localparam logic TURN_EN = (BUSTURN != 0);

    fmc_state_e             state_r;
    fmc_state_e             state_next_s;
    logic                   ready_r;
    logic                   wr_r;
    logic                   accept_s;
    logic                   wr_eff_s;
    logic                   rd_done_s;
    logic                   in_txn_s;
    logic                   cnt_load_s;
    logic                   cnt_en_s;
    logic [PHASE_CNT_W-1:0] cnt_load_val_s;
    logic                   cnt_zero_s;
    logic [2:0]             strobe_next_s;
    logic [2:0]             strobe_r;
    logic [ADDR_W-1:0]      addr_r;
    logic [DATA_W-1:0]      dout_r;
    logic                   doe_r;
    logic                   rsp_valid_r;
    logic [DATA_W-1:0]      rdata_r;

    // ready_r is only ever 1 while in IDLE, so it alone qualifies the handshake
    assign accept_s = io_cmd_valid && ready_r;
    // direction of the transaction being entered or in progress
    assign wr_eff_s = accept_s ? io_cmd_write : wr_r;

    fmc_phase_counter u_phase_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load_s),
        .en       (cnt_en_s),
        .load_val (cnt_load_val_s),
        .zero     (cnt_zero_s)
    );

    // Next-state logic and phase-counter control
    always_comb begin
        state_next_s   = state_r;
        cnt_load_s     = 1'b0;
        cnt_en_s       = 1'b0;
        cnt_load_val_s = '0;
        rd_done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s   = ST_SETUP;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = phase_load(ADDSET);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_zero_s) begin
                    state_next_s   = ST_DATA;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = phase_load(DATAST);
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_zero_s && wr_r) begin
                    state_next_s = ST_HOLD;
                end else if (cnt_zero_s) begin
                    rd_done_s = 1'b1;
                    if (TURN_EN) begin
                        state_next_s   = ST_TURN;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = phase_load(BUSTURN);
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            ST_HOLD: begin
                if (TURN_EN) begin
                    state_next_s   = ST_TURN;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = phase_load(BUSTURN);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_TURN: begin
                if (cnt_zero_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Strobe levels for the state being entered; NOE and NWE are qualified by
    // opposite directions so they can never be low together
    always_comb begin
        in_txn_s = (state_next_s == ST_SETUP) || (state_next_s == ST_DATA) ||
                   (state_next_s == ST_HOLD);
        strobe_next_s[2] = !in_txn_s;
        strobe_next_s[1] = !(!wr_eff_s && ((state_next_s == ST_SETUP) ||
                                           (state_next_s == ST_DATA)));
        strobe_next_s[0] = !(wr_eff_s && (state_next_s == ST_DATA));
    end

    // State register and command ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_IDLE);
        end
    end

    // Command capture: direction, address and (for writes) data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_r   <= 1'b0;
            addr_r <= '0;
            dout_r <= '0;
        end else if (accept_s) begin
            wr_r   <= io_cmd_write;
            addr_r <= io_cmd_addr;
            if (io_cmd_write) begin
                dout_r <= io_cmd_wdata;
            end
        end
    end

    // FMC strobes and data output enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_r <= STROBE_IDLE;
            doe_r    <= 1'b0;
        end else begin
            strobe_r <= strobe_next_s;
            doe_r    <= wr_eff_s && in_txn_s;
        end
    end

    // Read response: sample D_in on the edge that ends the last DATA cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rdata_r     <= '0;
        end else begin
            rsp_valid_r <= rd_done_s;
            if (rd_done_s) begin
                rdata_r <= io_fmc_master_D_in;
            end
        end
    end

    assign io_cmd_ready        = ready_r;
    assign io_rsp_valid        = rsp_valid_r;
    assign io_rsp_rdata        = rdata_r;
    assign io_fmc_master_A     = addr_r;
    assign io_fmc_master_D_out = dout_r;
    assign io_fmc_master_D_oe  = doe_r;
    assign io_fmc_master_NE    = strobe_r[2];
    assign io_fmc_master_NOE   = strobe_r[1];
    assign io_fmc_master_NWE   = strobe_r[0];

endmodule

// File: tb/tb_fmc_master.sv
// Self-checking bench for fmc_master. Two instances: "a" with the default
// timing (ADDSET=2, DATAST=4, BUSTURN=1) and "b" with the minimum timing
// (ADDSET=1, DATAST=1, BUSTURN=0). The expected waveform of every cycle is
// derived from the bus-cycle timing rules as a function of the cycle offset
// k after the accepting edge.
module tb_fmc_master;

    localparam int AW = 26;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          sel;
    logic          cmd_valid;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW-1:0] d_in;

    logic          valid_a, ready_a, rsp_valid_a, doe_a, ne_a, noe_a, nwe_a;
    logic [DW-1:0] rdata_a, dout_a;
    logic [AW-1:0] addr_a;
    logic          valid_b, ready_b, rsp_valid_b, doe_b, ne_b, noe_b, nwe_b;
    logic [DW-1:0] rdata_b, dout_b;
    logic [AW-1:0] addr_b;

    logic          ready_v, rsp_valid_v, doe_v, ne_v, noe_v, nwe_v;
    logic [DW-1:0] rdata_v, dout_v;
    logic [AW-1:0] addr_v;

    assign valid_a = cmd_valid & ~sel;
    assign valid_b = cmd_valid & sel;

    assign ready_v     = sel ? ready_b     : ready_a;
    assign rsp_valid_v = sel ? rsp_valid_b : rsp_valid_a;
    assign doe_v       = sel ? doe_b       : doe_a;
    assign ne_v        = sel ? ne_b        : ne_a;
    assign noe_v       = sel ? noe_b       : noe_a;
    assign nwe_v       = sel ? nwe_b       : nwe_a;
    assign rdata_v     = sel ? rdata_b     : rdata_a;
    assign dout_v      = sel ? dout_b      : dout_a;
    assign addr_v      = sel ? addr_b      : addr_a;

    fmc_master #(.ADDSET(2), .DATAST(4), .BUSTURN(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .io_cmd_valid(valid_a), .io_cmd_ready(ready_a), .io_cmd_write(cmd_write),
        .io_cmd_addr(cmd_addr), .io_cmd_wdata(cmd_wdata),
        .io_rsp_valid(rsp_valid_a), .io_rsp_rdata(rdata_a),
        .io_fmc_master_A(addr_a), .io_fmc_master_D_out(dout_a),
        .io_fmc_master_D_oe(doe_a), .io_fmc_master_D_in(d_in),
        .io_fmc_master_NE(ne_a), .io_fmc_master_NOE(noe_a), .io_fmc_master_NWE(nwe_a)
    );

    fmc_master #(.ADDSET(1), .DATAST(1), .BUSTURN(0)) u_dut_b (
        .clk(clk), .reset(reset),
        .io_cmd_valid(valid_b), .io_cmd_ready(ready_b), .io_cmd_write(cmd_write),
        .io_cmd_addr(cmd_addr), .io_cmd_wdata(cmd_wdata),
        .io_rsp_valid(rsp_valid_b), .io_rsp_rdata(rdata_b),
        .io_fmc_master_A(addr_b), .io_fmc_master_D_out(dout_b),
        .io_fmc_master_D_oe(doe_b), .io_fmc_master_D_in(d_in),
        .io_fmc_master_NE(ne_b), .io_fmc_master_NOE(noe_b), .io_fmc_master_NWE(nwe_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state per instance
    logic [DW-1:0] exp_rdata [2];
    logic [DW-1:0] exp_dout  [2];
    logic [AW-1:0] exp_addr  [2];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_rdata[i] = '0;
            exp_dout[i]  = '0;
            exp_addr[i]  = '0;
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_ready);
        check_val({tag, "_ne"},    ne_v,        1);
        check_val({tag, "_noe"},   noe_v,       1);
        check_val({tag, "_nwe"},   nwe_v,       1);
        check_val({tag, "_doe"},   doe_v,       0);
        check_val({tag, "_ready"}, ready_v,     exp_ready);
        check_val({tag, "_rspv"},  rsp_valid_v, 0);
        check_val({tag, "_addr"},  addr_v,      exp_addr[sel ? 1 : 0]);
        check_val({tag, "_dout"},  dout_v,      exp_dout[sel ? 1 : 0]);
        check_val({tag, "_rdata"}, rdata_v,     exp_rdata[sel ? 1 : 0]);
    endtask

    // One transaction on the selected instance. With chain=1 valid stays high
    // and the next command's fields are presented right after acceptance.
    // abort_k >= 0 asserts reset during cycle abort_k and returns.
    task automatic do_txn(input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                          input logic chain, input logic nwr,
                          input logic [AW-1:0] naddr, input logic [DW-1:0] nwd,
                          input int abort_k);
        int as, ds, bt, len, idx, waited;
        idx = sel ? 1 : 0;
        as  = sel ? 1 : 2;
        ds  = sel ? 1 : 4;
        bt  = sel ? 0 : 1;
        len = as + ds + (wr ? 1 : 0);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        waited = 0;
        while (ready_v !== 1'b1 && waited < 64) begin
            d_in = $urandom;
            @(posedge clk); #1;
            waited++;
        end
        check_val("accept_wait", (waited < 64), 1);
        if (waited >= 64) begin
            cmd_valid = 1'b0;
            return;
        end
        d_in = $urandom;
        @(posedge clk); #1;
        if (chain) begin
            cmd_write = nwr;
            cmd_addr  = naddr;
            cmd_wdata = nwd;
        end else begin
            cmd_valid = 1'b0;
            cmd_write = 1'($urandom);
            cmd_addr  = AW'($urandom);
            cmd_wdata = $urandom;
        end
        exp_addr[idx] = addr;
        if (wr) exp_dout[idx] = wd;
        for (int k = 0; k <= len + bt; k++) begin
            d_in = (!wr && k == as + ds - 1) ? rd : $urandom;
            if (!wr && k == len) exp_rdata[idx] = rd;
            check_val("ne",    ne_v,        (k < len) ? 0 : 1);
            check_val("noe",   noe_v,       (!wr && k < len) ? 0 : 1);
            check_val("nwe",   nwe_v,       (wr && k >= as && k < as + ds) ? 0 : 1);
            check_val("d_oe",  doe_v,       (wr && k < len) ? 1 : 0);
            check_val("addr",  addr_v,      exp_addr[idx]);
            check_val("d_out", dout_v,      exp_dout[idx]);
            check_val("rsp_valid", rsp_valid_v, (!wr && k == len) ? 1 : 0);
            check_val("rdata", rdata_v,     exp_rdata[idx]);
            check_val("ready", ready_v,     (k >= len + bt) ? 1 : 0);
            if (k == abort_k) begin
                #2 reset = 1'b1;
                cmd_valid = 1'b0;
                #1;
                model_reset();
                check_idle("abort", 1'b0);
                return;
            end
            if (k < len + bt) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // n random transactions on the selected instance, randomly chained
    task automatic random_run(input int n);
        logic          wr, nwr, chain;
        logic [AW-1:0] addr, naddr;
        logic [DW-1:0] wd, nwd;
        wr   = 1'($urandom);
        addr = AW'($urandom);
        wd   = $urandom;
        for (int i = 0; i < n; i++) begin
            nwr   = 1'($urandom);
            naddr = AW'($urandom);
            nwd   = $urandom;
            chain = (i < n - 1) ? 1'($urandom) : 1'b0;
            do_txn(wr, addr, wd, $urandom, chain, nwr, naddr, nwd, -1);
            if (!chain) begin
                repeat ($urandom_range(0, 3)) begin
                    d_in = $urandom;
                    @(posedge clk); #1;
                    check_val("gap_ne", ne_v, 1);
                end
            end
            wr   = nwr;
            addr = naddr;
            wd   = nwd;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel       = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        d_in      = '0;
        reset     = 1'b1;
        model_reset();

        // reset values, held for 4 cycles
        repeat (4) begin
            @(posedge clk); #1;
            sel = 1'b0; #0; check_idle("rst_a", 1'b0);
            sel = 1'b1; #0; check_idle("rst_b", 1'b0);
        end
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        sel = 1'b0; #0; check_idle("rel_a", 1'b1);
        sel = 1'b1; #0; check_idle("rel_b", 1'b1);
        sel = 1'b0;

        // directed read and write, default timing
        do_txn(1'b0, 26'h4000, 32'h0, 32'hCAFEBABE, 1'b0, 1'b0, '0, '0, -1);
        check_val("dir_rdata", rdata_v, 32'hCAFEBABE);
        do_txn(1'b1, 26'h0010, 32'h12345678, 32'h0, 1'b0, 1'b0, '0, '0, -1);
        random_run(20);

        // minimum timing: back-to-back read then write, valid held high
        sel = 1'b1; #1;
        do_txn(1'b0, 26'h155AA55, 32'h0, 32'h0F1E2D3C, 1'b1, 1'b1, 26'h2A5, 32'hA5A55A5A, -1);
        do_txn(1'b1, 26'h2A5, 32'hA5A55A5A, 32'h0, 1'b0, 1'b0, '0, '0, -1);
        // boundary address
        do_txn(1'b0, 26'h3FFFFFF, 32'h0, 32'h89ABCDEF, 1'b0, 1'b0, '0, '0, -1);
        check_val("bnd_rdata", rdata_v, 32'h89ABCDEF);
        do_txn(1'b1, 26'h3FFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, '0, '0, -1);
        random_run(20);

        // reset during the 2nd DATA cycle of a write, then a normal read
        sel = 1'b0; #1;
        do_txn(1'b1, 26'h0ABCDEF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, '0, '0, 3);
        repeat (2) begin
            @(posedge clk); #1;
            check_idle("in_rst", 1'b0);
        end
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check_idle("post_rst", 1'b1);
        do_txn(1'b0, 26'h0001234, 32'h0, 32'h5A5AA5A5, 1'b0, 1'b0, '0, '0, -1);
        random_run(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
